// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin A/B arbiter with a registered command bus and a full-memory clear sweep.
// Optional MEMARB_PERF_CNT_EN adds saturating grant and conflict counters.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int SIZE       = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_start,
  output logic                  clr_busy,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
`ifdef MEMARB_PERF_CNT_EN
  output logic [15:0]           a_gnt_cnt,
  output logic [15:0]           b_gnt_cnt,
  output logic [15:0]           conflict_cnt,
`endif
  output logic                  mem_cen,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q
);
  typedef enum logic {ARB, CLEAR} state_e;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(SIZE);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  ptr_q, ptr_d;
  logic                  cen_q, cen_d, wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic                  busy_q, busy_d;
  logic                  a_rv_q, b_rv_q;
  logic                  a_el, b_el, last, arb_en, pick_a, pick_b;
  always_comb begin
    a_el    = a_req & ~a_gnt_q;
    b_el    = b_req & ~b_gnt_q;
    last    = (state_q == CLEAR) && (cnt_q == LAST);
    arb_en  = ((state_q == ARB) && !clr_start) || last;
    pick_a  = arb_en & a_el & (~b_el | ~ptr_q);
    pick_b  = arb_en & b_el & ~pick_a;
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    cen_d   = 1'b0;
    wen_d   = wen_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    a_gnt_d = pick_a;
    b_gnt_d = pick_b;
    if ((state_q == ARB) && clr_start) begin
      state_d = CLEAR;
      cnt_d   = (ADDR_WIDTH+1)'(1);
      cen_d   = 1'b1;
      wen_d   = 1'b1;
      addr_d  = '0;
      data_d  = '0;
      busy_d  = 1'b1;
    end else if ((state_q == CLEAR) && !last) begin
      cnt_d   = cnt_q + (ADDR_WIDTH+1)'(1);
      cen_d   = 1'b1;
      wen_d   = 1'b1;
      addr_d  = cnt_q[ADDR_WIDTH-1:0];
      data_d  = '0;
    end else begin
      if (last) begin
        state_d = ARB;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
      // ptr_q=1 means B is favoured on the next tie
      if (pick_a | pick_b) begin
        cen_d  = 1'b1;
        wen_d  = pick_a ? a_we : b_we;
        addr_d = pick_a ? a_addr : b_addr;
        data_d = pick_a ? a_wdata : b_wdata;
        ptr_d  = pick_a;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      cen_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
      a_rv_q  <= 1'b0;
      b_rv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      cen_q   <= cen_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      a_gnt_q <= a_gnt_d;
      b_gnt_q <= b_gnt_d;
      a_rv_q  <= a_gnt_q & ~wen_q;
      b_rv_q  <= b_gnt_q & ~wen_q;
    end
  end
  assign mem_cen  = cen_q;
  assign mem_wen  = wen_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign clr_busy = busy_q;
  assign a_rvalid = a_rv_q;
  assign b_rvalid = b_rv_q;
  assign a_rdata  = a_rv_q ? mem_q : '0;
  assign b_rdata  = b_rv_q ? mem_q : '0;
`ifdef MEMARB_PERF_CNT_EN
  logic [15:0] a_cnt_q, b_cnt_q, c_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      c_cnt_q <= '0;
    end else if (clr_start) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      c_cnt_q <= '0;
    end else begin
      a_cnt_q <= (a_gnt_q && a_cnt_q != 16'hFFFF) ? a_cnt_q + 16'd1 : a_cnt_q;
      b_cnt_q <= (b_gnt_q && b_cnt_q != 16'hFFFF) ? b_cnt_q + 16'd1 : b_cnt_q;
      c_cnt_q <= (arb_en && a_el && b_el && c_cnt_q != 16'hFFFF) ? c_cnt_q + 16'd1 : c_cnt_q;
    end
  end
  assign a_gnt_cnt    = a_cnt_q;
  assign b_gnt_cnt    = b_cnt_q;
  assign conflict_cnt = c_cnt_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus clear-sweep and async-reset sequences against a memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [11:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_cen, mem_wen;
  logic [11:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] mem_q = '0;
  logic [31:0] mem [0:4095];
  int          checks = 0;
  int          errors = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .clr_busy(clr_busy),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_cen && mem_wen) mem[mem_addr] <= mem_data;
    mem_q <= (mem_cen && !mem_wen) ? mem[mem_addr] : 32'h0;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic ar, aw; logic [11:0] aa; logic [31:0] ad;
    logic br, bw; logic [11:0] ba; logic [31:0] bd;
    logic ag, bg, arv, brv, cen, wen; logic [11:0] ma; logic [31:0] md, ard, brd;
  } vec_t;
  vec_t tbl[$];

  task automatic row(input logic ar, aw, input logic [11:0] aa, input logic [31:0] ad,
                     input logic br, bw, input logic [11:0] ba, input logic [31:0] bd,
                     input logic ag, bg, arv, brv, cen, wen, input logic [11:0] ma,
                     input logic [31:0] md, ard, brd);
    tbl.push_back('{ar, aw, aa, ad, br, bw, ba, bd, ag, bg, arv, brv, cen, wen, ma, md, ard, brd});
  endtask

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {13'b0, a_gnt, b_gnt, a_rvalid, b_rvalid, mem_cen, mem_wen, clr_busy,
            mem_addr, mem_data, a_rdata, b_rdata};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic acc(input bit port, input logic we, input logic [11:0] ad, input logic [31:0] d);
    int n = 0;
    if (!port) begin a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = d; end
    else       begin b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = d; end
    do begin cyc(); n++; end while (!(port ? b_gnt : a_gnt) && n < 8);
    chk(port ? "acc_b_gnt" : "acc_a_gnt", {127'b0, port ? b_gnt : a_gnt}, 128'd1);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  initial begin
    int good, busy, n;
    // contention from reset: A first, then strict alternation
    row(1,0,12'h001,0, 1,0,12'h002,0, 0,0,0,0,0,0,12'h000,0,0,0);
    row(1,0,12'h001,0, 1,0,12'h002,0, 1,0,0,0,1,0,12'h001,0,0,0);
    row(1,0,12'h001,0, 1,0,12'h002,0, 0,1,1,0,1,0,12'h002,0,32'h11111111,0);
    row(1,0,12'h001,0, 1,0,12'h002,0, 1,0,0,1,1,0,12'h001,0,0,32'h22222222);
    row(0,0,12'h000,0, 0,0,12'h000,0, 0,1,1,0,1,0,12'h002,0,32'h11111111,0);
    row(0,0,12'h000,0, 0,0,12'h000,0, 0,0,0,1,0,0,12'h002,0,0,32'h22222222);
    // write then read on A
    row(1,1,12'h010,32'hDEADBEEF, 0,0,12'h000,0, 0,0,0,0,0,0,12'h002,0,0,0);
    row(1,1,12'h010,32'hDEADBEEF, 0,0,12'h000,0, 1,0,0,0,1,1,12'h010,32'hDEADBEEF,0,0);
    row(1,0,12'h010,0, 0,0,12'h000,0, 0,0,0,0,0,1,12'h010,32'hDEADBEEF,0,0);
    row(1,0,12'h010,0, 0,0,12'h000,0, 1,0,0,0,1,0,12'h010,0,0,0);
    row(0,0,12'h000,0, 0,0,12'h000,0, 0,0,1,0,0,0,12'h010,0,32'hDEADBEEF,0);
    // B alone holds req for 6 cycles: three grants on alternate cycles
    row(0,0,12'h000,0, 1,0,12'h002,0, 0,0,0,0,0,0,12'h010,0,0,0);
    row(0,0,12'h000,0, 1,0,12'h002,0, 0,1,0,0,1,0,12'h002,0,0,0);
    row(0,0,12'h000,0, 1,0,12'h002,0, 0,0,0,1,0,0,12'h002,0,0,32'h22222222);
    row(0,0,12'h000,0, 1,0,12'h002,0, 0,1,0,0,1,0,12'h002,0,0,0);
    row(0,0,12'h000,0, 1,0,12'h002,0, 0,0,0,1,0,0,12'h002,0,0,32'h22222222);
    row(0,0,12'h000,0, 1,0,12'h002,0, 0,1,0,0,1,0,12'h002,0,0,0);
    row(0,0,12'h000,0, 0,0,12'h000,0, 0,0,0,1,0,0,12'h002,0,0,32'h22222222);
    // tie after B served: A wins, then B write
    row(1,0,12'h010,0, 1,1,12'h020,32'hCAFEF00D, 0,0,0,0,0,0,12'h002,0,0,0);
    row(1,0,12'h010,0, 1,1,12'h020,32'hCAFEF00D, 1,0,0,0,1,0,12'h010,0,0,0);
    row(0,0,12'h000,0, 1,1,12'h020,32'hCAFEF00D, 0,1,1,0,1,1,12'h020,32'hCAFEF00D,32'hDEADBEEF,0);
    row(0,0,12'h000,0, 0,0,12'h000,0, 0,0,0,0,0,1,12'h020,32'hCAFEF00D,0,0);

    #3 chk("reset_outs", outs(), 128'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    acc(0, 1'b1, 12'h001, 32'h11111111);
    acc(1, 1'b1, 12'h002, 32'h22222222);
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      {a_req, a_we, a_addr, a_wdata} = {tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].ad};
      {b_req, b_we, b_addr, b_wdata} = {tbl[i].br, tbl[i].bw, tbl[i].ba, tbl[i].bd};
      #1 chk($sformatf("vec%0d", i), outs(),
             {13'b0, tbl[i].ag, tbl[i].bg, tbl[i].arv, tbl[i].brv, tbl[i].cen, tbl[i].wen, 1'b0,
              tbl[i].ma, tbl[i].md, tbl[i].ard, tbl[i].brd});
      cyc();
    end

    acc(0, 1'b1, 12'h000, 32'd5);
    acc(0, 1'b1, 12'hFFF, 32'd7);
    cyc();
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h020;
    cyc();
    chk("xclr_b_gnt", {127'b0, b_gnt}, 128'd1);
    b_req = 1'b0;
    clr_start = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'h000; a_wdata = 32'h0;
    cyc();
    clr_start = 1'b0;
    chk("clr_first", {b_rvalid, b_rdata, clr_busy, mem_cen, mem_wen, mem_addr, mem_data, a_gnt, b_gnt},
        {1'b1, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 12'h000, 32'h0, 1'b0, 1'b0});
    good = 0;
    busy = 1;
    for (int k = 1; k < 4096; k++) begin
      cyc();
      clr_start = (k == 50);
      if (clr_busy && mem_cen && mem_wen && mem_addr == 12'(k) && mem_data == 0 && !a_gnt && !b_gnt)
        good++;
      busy += int'(clr_busy);
    end
    clr_start = 1'b0;
    chk("sweep_cycles", 128'(good), 128'd4095);
    chk("busy_cycles", 128'(busy), 128'd4096);
    cyc();
    chk("post_clr_a_gnt", {clr_busy, a_gnt, mem_cen, mem_wen, mem_addr}, {1'b0, 1'b1, 1'b1, 1'b0, 12'h000});
    a_req = 1'b0;
    cyc();
    chk("rd000_after_clr", {a_rvalid, a_rdata}, {1'b1, 32'h0});
    acc(0, 1'b0, 12'hFFF, 32'h0);
    cyc();
    chk("rdFFF_after_clr", {a_rvalid, a_rdata}, {1'b1, 32'h0});

    cyc();
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    n = 0;
    while (mem_addr != 12'd100 && n < 200) begin cyc(); n++; end
    chk("reach_addr100", {clr_busy, mem_addr}, {1'b1, 12'd100});
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'h001;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h002;
    #2 rst_n = 1'b0;
    #1 chk("async_rst_outs", outs(), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_release_outs", outs(), 128'd0);
    cyc();
    chk("a_first", {a_gnt, b_gnt, clr_busy, mem_addr}, {1'b1, 1'b0, 1'b0, 12'h001});
    a_req = 1'b0;
    cyc();
    chk("b_second", {b_gnt, a_gnt, a_rvalid, mem_addr}, {1'b1, 1'b0, 1'b1, 12'h002});
    b_req = 1'b0;
    cyc();
    chk("b_rvalid_after_rst", {b_rvalid, a_rvalid, mem_cen}, {1'b1, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
